// File: rtl/step_board_pkg.sv
// rtl/step_board_pkg.sv - board-wide constants and debounce FSM state encoding
package step_board_pkg;

   localparam int CLK_FREQ_HZ     = 12_000_000;
   localparam int DEBOUNCE_MS     = 20;
   localparam int DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SETTLE = 1'b1
   } db_state_t;

endpackage

// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - raw switch levels in, debounced levels and edge pulses out
interface switch_debounce_if #(
   parameter int N = 2
);

   logic [N-1:0] sw_in;
   logic [N-1:0] sw_out;
   logic [N-1:0] sw_rise;
   logic [N-1:0] sw_fall;

   // Switch side: drives raw levels, consumes clean levels and pulses.
   modport master (
      output sw_in,
      input  sw_out,
      input  sw_rise,
      input  sw_fall
   );

   // Debouncer side.
   modport slave (
      input  sw_in,
      output sw_out,
      output sw_rise,
      output sw_fall
   );

endinterface

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one debounce channel: synchroniser, stability counter, FSM, edge pulses
module debounce_ch
   import step_board_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             mismatch;

   assign mismatch = sync2_q ^ out_q;

   // Two-flop synchroniser for the asynchronous raw switch level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
      end
   end

   // FSM state, stability counter, debounced level and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Follow the synchronised level only after an unbroken run of STABLE_CYCLES mismatches.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (mismatch) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_ONE;
            end
         end
         ST_SETTLE: begin
            if (!mismatch) begin
               // Bounced back before the window closed: forget the whole run.
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               out_d   = sync2_q;
               rise_d  = sync2_q;
               fall_d  = ~sync2_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign sw_o   = out_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - N independent debounce channels feeding the comparator operands
module switch_debounce
   import step_board_pkg::*;
#(
   parameter int N             = 2,
   parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   switch_debounce_if.slave  sw
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_ch #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .sw_i  (sw.sw_in[i]),
         .sw_o  (sw.sw_out[i]),
         .rise_o(sw.sw_rise[i]),
         .fall_o(sw.sw_fall[i])
      );
   end

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce (N=2, STABLE_CYCLES=4)
module tb_switch_debounce;

   localparam int N = 2;
   localparam int S = 4;

   typedef struct {
      string      tag;
      logic [1:0] out;
      logic [1:0] rise;
      logic [1:0] fall;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   switch_debounce_if #(.N(N)) sw_if ();

   switch_debounce #(
      .N            (N),
      .STABLE_CYCLES(S)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw_if)
   );

   exp_t       exp_q[$];
   int         total = 0;
   int         bad   = 0;
   int         rise_cnt[N];
   int         fall_cnt[N];

   // reference: raw samples per channel, newest at index 0
   logic       hist[N][S+2];
   logic [1:0] mout;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++)
         for (int j = 0; j < S + 2; j++)
            hist[c][j] = 1'b0;
      mout = 2'b00;
   endtask

   // Drive one raw sample (taken at the next rising edge) and queue the outputs expected after it.
   // The output moves to v at edge e when raw samples e-1-S .. e-2 all equal v and differ from it.
   task automatic drive(input string tag, input logic [1:0] v);
      logic [1:0] er, ef;
      logic       all_eq;
      @(negedge clk);
      sw_if.sw_in = v;
      er = 2'b00;
      ef = 2'b00;
      for (int c = 0; c < N; c++) begin
         for (int j = S + 1; j > 0; j--)
            hist[c][j] = hist[c][j-1];
         hist[c][0] = v[c];
         all_eq = 1'b1;
         for (int j = 2; j <= S + 1; j++)
            if (hist[c][j] != hist[c][2]) all_eq = 1'b0;
         if (all_eq && (hist[c][2] != mout[c])) begin
            mout[c] = hist[c][2];
            er[c]   = mout[c];
            ef[c]   = ~mout[c];
         end
      end
      exp_q.push_back('{tag: tag, out: mout, rise: er, fall: ef});
      @(posedge clk);
   endtask

   task automatic seg(input string tag, input logic [1:0] v, input int n);
      for (int i = 0; i < n; i++) drive(tag, v);
   endtask

   // Monitor: compare each cycle's outputs against the queued expectation, tally pulses.
   always begin : mon
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val({e.tag, "/out"},  32'(sw_if.sw_out),  32'(e.out));
         check_val({e.tag, "/rise"}, 32'(sw_if.sw_rise), 32'(e.rise));
         check_val({e.tag, "/fall"}, 32'(sw_if.sw_fall), 32'(e.fall));
      end
      for (int c = 0; c < N; c++) begin
         rise_cnt[c] += int'(sw_if.sw_rise[c]);
         fall_cnt[c] += int'(sw_if.sw_fall[c]);
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int r0, r1, f0, f1;
      for (int c = 0; c < N; c++) begin
         rise_cnt[c] = 0;
         fall_cnt[c] = 0;
      end
      sw_if.sw_in = 2'b00;
      rst_n       = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst/out",  32'(sw_if.sw_out),  32'd0);
      check_val("rst/rise", 32'(sw_if.sw_rise), 32'd0);
      check_val("rst/fall", 32'(sw_if.sw_fall), 32'd0);
      #3 rst_n = 1'b1;

      // idle after reset
      r0 = rise_cnt[0]; r1 = rise_cnt[1];
      seg("idle", 2'b00, 20);
      #2;
      check_val("idle/pulses", 32'(rise_cnt[0] - r0 + rise_cnt[1] - r1), 32'd0);

      // single clean rise on channel 0
      r0 = rise_cnt[0]; r1 = rise_cnt[1];
      seg("rise0", 2'b01, 10);
      #2;
      check_val("rise0/cnt0", 32'(rise_cnt[0] - r0), 32'd1);
      check_val("rise0/cnt1", 32'(rise_cnt[1] - r1), 32'd0);

      // bouncing channel 1 settling high
      r1 = rise_cnt[1]; f1 = fall_cnt[1];
      drive("bounce", 2'b11);
      drive("bounce", 2'b01);
      drive("bounce", 2'b11);
      drive("bounce", 2'b01);
      seg("bounce", 2'b11, 10);
      #2;
      check_val("bounce/rise1", 32'(rise_cnt[1] - r1), 32'd1);
      check_val("bounce/fall1", 32'(fall_cnt[1] - f1), 32'd0);

      // 3-cycle glitch on channel 0 from stable 0
      seg("pre_glitch", 2'b10, 8);
      r0 = rise_cnt[0]; f0 = fall_cnt[0];
      seg("glitch", 2'b11, 3);
      seg("glitch", 2'b10, 8);
      #2;
      check_val("glitch/rise0", 32'(rise_cnt[0] - r0), 32'd0);
      check_val("glitch/fall0", 32'(fall_cnt[0] - f0), 32'd0);

      // both channels fall on the same edge
      seg("pre_fall", 2'b11, 8);
      f0 = fall_cnt[0]; f1 = fall_cnt[1];
      seg("fall_both", 2'b00, 8);
      #2;
      check_val("fall_both/f0", 32'(fall_cnt[0] - f0), 32'd1);
      check_val("fall_both/f1", 32'(fall_cnt[1] - f1), 32'd1);

      // asynchronous reset while settling a fall from 11
      seg("pre_rst", 2'b11, 8);
      seg("settle", 2'b00, 3);
      #3;
      check_val("pre_rst/out", 32'(sw_if.sw_out), 32'd3);
      rst_n       = 1'b0;
      sw_if.sw_in = 2'b11;
      #1;
      check_val("async_rst/out",  32'(sw_if.sw_out),  32'd0);
      check_val("async_rst/rise", 32'(sw_if.sw_rise), 32'd0);
      check_val("async_rst/fall", 32'(sw_if.sw_fall), 32'd0);
      model_reset();
      @(posedge clk);
      #4 rst_n = 1'b1;
      r0 = rise_cnt[0]; r1 = rise_cnt[1];
      seg("post_rst", 2'b11, 8);
      #2;
      check_val("post_rst/rise0", 32'(rise_cnt[0] - r0), 32'd1);
      check_val("post_rst/rise1", 32'(rise_cnt[1] - r1), 32'd1);
      check_val("post_rst/out",   32'(sw_if.sw_out),     32'd3);

      repeat (2) @(posedge clk);
      #2;
      check_val("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Debounces and synchronises N raw slide-switch / key inputs and produces clean levels plus one-cycle edge pulses. Sits directly upstream of the one-bit comparator, feeding its `a` and `b` operands (channel 0 → `a`, channel 1 → `b`) so the three result LEDs never flicker on contact bounce. Runs on the board clock; the comparator downstream stays purely combinational.

## Interface
- `N`, 2, number of independent channels.
- `STABLE_CYCLES`, 240000, cycles a synchronised input must differ from the output before the output follows (20 ms at 12 MHz); legal range ≥ 2.
- `clk`  input  1  system clock (12 MHz on the board).
- `rst_n`  input  1  asynchronous, active-low reset; one clock domain only.
- `sw_in`  input  N  raw, asynchronous switch levels.
- `sw_out`  output  N  debounced level per channel.
- `sw_rise`  output  N  one-cycle pulse when `sw_out[i]` goes 0→1.
- `sw_fall`  output  N  one-cycle pulse when `sw_out[i]` goes 1→0.

## Operation
- Per channel, fully independent; no cross-channel interaction.
- Two-flop synchroniser `sync1 → sync2` on `sw_in[i]`.
- Counter `cnt`, width `$clog2(STABLE_CYCLES)`, unsigned, never wraps.
- Two-state FSM per channel:
  - IDLE: `sync2 == sw_out`; `cnt` held at 0. Mismatch → SETTLE, `cnt` ← 1.
  - SETTLE: while mismatch and `cnt < STABLE_CYCLES-1`, `cnt` ← `cnt+1`. Mismatch and `cnt == STABLE_CYCLES-1` → `sw_out` ← `sync2`, matching edge pulse asserted, `cnt` ← 0, → IDLE. Match (bounce back) → `cnt` ← 0, → IDLE, no output change, no pulse.
- Any mismatch run shorter than `STABLE_CYCLES` cycles is discarded completely; the count restarts from 1 on the next mismatch.
- `sw_rise[i]` and `sw_fall[i]` are never high together; pulses are registered, exactly one cycle wide.
- Reset (asynchronous assert, any time, including mid-SETTLE): `sync1`, `sync2`, `cnt`, `sw_out`, `sw_rise`, `sw_fall` all 0, FSM → IDLE. Reset deassertion is synchronous to `clk` at system level.
- After reset release with `sw_in[i]` = 1, the channel treats it as a normal 0→1 change: `sw_out` rises and `sw_rise` pulses after the full latency.

## Timing
- Raw change sampled at edge k (into `sync1`); `sync2` updates at edge k+1; `sw_out` and pulse update at edge k+1+`STABLE_CYCLES`, provided `sync2` stays constant through that window.
- Pulse is high for the cycle following that edge only, deasserted at edge k+2+`STABLE_CYCLES`.
- Raw reversal that reaches `sync2` at or before edge k+`STABLE_CYCLES` cancels the change.
- Throughput: a new stable level can be accepted immediately after an output update; minimum spacing between successive output toggles is `STABLE_CYCLES`+1 cycles... plus synchroniser delay only on the first.
- All outputs registered; no combinational path from `sw_in` to any output.

## Structure
- Shared package `step_board_pkg`: `CLK_FREQ_HZ` = 12_000_000, `DEBOUNCE_MS` = 20, derived `DEBOUNCE_CYCLES`; FSM state encoding `ST_IDLE` = 1'b0, `ST_SETTLE` = 1'b1.
- Sub-module `debounce_ch`: one channel (synchroniser, counter, FSM, edge pulses). `switch_debounce` is a generate loop of N instances.

## Test plan
Bench runs with `N` = 2, `STABLE_CYCLES` = 4.
- Reset with `sw_in` = 2'b00 → all outputs 0; release, hold 20 cycles → outputs stay 0, no pulses.
- `sw_in[0]` 0→1 sampled at edge 0, held → `sw_out[0]` = 1 at edge 5, `sw_rise[0]` high for exactly one cycle, channel 1 unchanged.
- `sw_in[1]` bounce 1,0,1,0 one cycle each then settles at 1 → no output change during bounce; `sw_out[1]` rises 5 edges after final settle sample; exactly one `sw_rise[1]` pulse.
- 3-cycle glitch 1 on `sw_in[0]` from stable 0 → `sw_out[0]` stays 0, no pulses.
- Both channels 1→0 on the same edge → `sw_out` = 2'b00 and `sw_fall` = 2'b11 on the same cycle, then `sw_fall` = 2'b00.
- `rst_n` asserted mid-SETTLE with `sw_in` = 2'b11 → outputs 0 immediately (asynchronous); after release, `sw_out` = 2'b11 at edge 5 with `sw_rise` = 2'b11 for one cycle.
